// File: rtl/adc_if_pkg.sv
// Shared types and timing defaults for the ADC read path.
// Used by the read controller and its bench.
package adc_if_pkg;

  localparam int DATA_W     = 8;
  localparam int CONV_PULSE = 4;
  localparam int RD_CYCLES  = 3;
  localparam int TIMEOUT    = 64;
  localparam int CNT_W      = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_WAIT_EOC,
    ST_READ,
    ST_DONE
  } state_t;

  // Counters stop at all-ones instead of wrapping.
  function automatic cnt_t cnt_inc(input cnt_t c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser; resets to all ones so an
// idle active-low input reads inactive.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc_read_ctrl.sv
// Reader side of the parallel ADC handshake:
// convst pulse, EOC wait with timeout, cs/rd strobe.
module adc_read_ctrl
  import adc_if_pkg::*;
#(
  parameter int DATA_W     = adc_if_pkg::DATA_W,
  parameter int CONV_PULSE = adc_if_pkg::CONV_PULSE,
  parameter int RD_CYCLES  = adc_if_pkg::RD_CYCLES,
  parameter int TIMEOUT    = adc_if_pkg::TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              eoc_bar,
  input  logic [DATA_W-1:0] adc_data,
  output logic              convst_bar,
  output logic              cs_bar,
  output logic              rd_bar,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              busy,
  output logic              timeout_err,
  output logic              overrun
);

  if (CONV_PULSE < 1 || CONV_PULSE > 15) begin : g_bad_cp
    $error("CONV_PULSE out of range 1..15");
  end
  if (RD_CYCLES < 1 || RD_CYCLES > 15) begin : g_bad_rd
    $error("RD_CYCLES out of range 1..15");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_to
    $error("TIMEOUT out of range 2..255");
  end

  localparam cnt_t CP_LAST = cnt_t'(CONV_PULSE - 1);
  localparam cnt_t RD_LAST = cnt_t'(RD_CYCLES - 1);
  localparam cnt_t TO_LAST = cnt_t'(TIMEOUT - 1);

  state_t            state;
  state_t            state_n;
  cnt_t              cnt;
  cnt_t              cnt_n;
  logic              eoc_s;
  logic              rd_q;
  logic              convst_n;
  logic              rd_n;
  logic              busy_n;
  logic              valid_n;
  logic              tmo_n;
  logic              ovr_n;
  logic [DATA_W-1:0] sample_n;

  sync_2ff #(
    .W (1)
  ) u_eoc_sync (
    .clk (clk),
    .rst (rst),
    .d   (eoc_bar),
    .q   (eoc_s)
  );

  assign cs_bar = rd_q;
  assign rd_bar = rd_q;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    convst_n = 1'b1;
    rd_n     = 1'b1;
    busy_n   = 1'b1;
    valid_n  = 1'b0;
    tmo_n    = 1'b0;
    sample_n = sample;
    // Requests outside IDLE are flagged and dropped.
    ovr_n    = start && (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          state_n  = ST_CONV;
          cnt_n    = '0;
          convst_n = 1'b0;
          busy_n   = 1'b1;
        end
      end
      ST_CONV: begin
        if (cnt == CP_LAST) begin
          state_n = ST_WAIT_EOC;
          cnt_n   = '0;
        end else begin
          convst_n = 1'b0;
          cnt_n    = cnt_inc(cnt);
        end
      end
      ST_WAIT_EOC: begin
        // EOC beats the timeout on the final count.
        if (!eoc_s) begin
          state_n = ST_READ;
          cnt_n   = '0;
          rd_n    = 1'b0;
        end else if (cnt == TO_LAST) begin
          state_n = ST_IDLE;
          tmo_n   = 1'b1;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt_inc(cnt);
        end
      end
      ST_READ: begin
        if (cnt == RD_LAST) begin
          state_n  = ST_DONE;
          sample_n = adc_data;
          valid_n  = 1'b1;
        end else begin
          rd_n  = 1'b0;
          cnt_n = cnt_inc(cnt);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      convst_bar   <= 1'b1;
      rd_q         <= 1'b1;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      convst_bar   <= convst_n;
      rd_q         <= rd_n;
      sample       <= sample_n;
      sample_valid <= valid_n;
      busy         <= busy_n;
      timeout_err  <= tmo_n;
      overrun      <= ovr_n;
    end
  end

endmodule
